// File: rtl/acc_pkg.sv
// Shared register offsets, CTRL bit positions and FSM states for the
// accumulator-window multiply-accumulate responder.
package acc_pkg;

    localparam logic [1:0] ACC_OPA  = 2'd0;
    localparam logic [1:0] ACC_OPB  = 2'd1;
    localparam logic [1:0] ACC_ACC  = 2'd2;
    localparam logic [1:0] ACC_CTRL = 2'd3;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;

    // CTRL read bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ACCUM = 2'd2
    } acc_state_e;

endpackage

// File: rtl/mul_serial.sv
// Shift-add multiplier datapath: one multiplier bit per step, product
// truncated to WIDTH bits; last flags the final step of a multiply.
module mul_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Operand and product registers carry no reset; load always precedes use.
    always_ff @(posedge clk) begin
        if (load) begin
            mcand  <= a;
            mplier <= b;
            prod   <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/acc_mac_resp.sv
// Memory-mapped multiply-accumulate responder: OPA/OPB/ACC/CTRL register
// file, bus decode and the IDLE/RUN/ACCUM sequencer around mul_serial.
module acc_mac_resp
    import acc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       addr,
    input  logic [3:0]       we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             busy
);

    localparam int NB = (WIDTH / 8 < 4) ? WIDTH / 8 : 4;

    acc_state_e state;
    acc_state_e state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             done;
    logic             ovf;

    logic [1:0]       sel;
    logic             wr;
    logic             start_req;
    logic             start_acc;
    logic             mul_step;
    logic             accum;
    logic [WIDTH-1:0] prod;
    logic             mul_last;
    logic [WIDTH:0]   acc_sum;
    logic             unused_addr;

    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] nw,
        input logic [3:0]       be
    );
        logic [WIDTH-1:0] r;
        r = cur;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                r[i*8 +: 8] = nw[i*8 +: 8];
            end
        end
        return r;
    endfunction

    assign sel         = addr[3:2];
    assign unused_addr = ^addr[1:0];
    assign wr          = en && (we != 4'b0000);
    assign start_req   = wr && (sel == ACC_CTRL) && we[0] && wdata[CTRL_START];
    assign busy        = (state != IDLE);
    assign acc_sum     = {1'b0, acc} + {1'b0, prod};

    mul_serial #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc),
        .step  (mul_step),
        .a     (opa),
        .b     (opb),
        .prod  (prod),
        .last  (mul_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start is only accepted from IDLE; starts while busy fall through.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        mul_step  = 1'b0;
        accum     = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    start_acc = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                accum     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay writable mid-run: the multiplier copied them at start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa  <= '0;
            opb  <= '0;
            acc  <= '0;
            done <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (wr && (sel == ACC_OPA)) begin
                opa <= byte_merge(opa, wdata, we);
            end
            if (wr && (sel == ACC_OPB)) begin
                opb <= byte_merge(opb, wdata, we);
            end

            if (accum) begin
                acc <= acc_sum[WIDTH-1:0];
            end else if (start_acc && wdata[CTRL_CLR]) begin
                acc <= '0;
            end else if (wr && (sel == ACC_ACC) && !busy) begin
                acc <= byte_merge(acc, wdata, we);
            end

            if (start_acc) begin
                done <= 1'b0;
                ovf  <= 1'b0;
            end else if (accum) begin
                done <= 1'b1;
                ovf  <= acc_sum[WIDTH];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (en) begin
            case (sel)
                ACC_OPA:  rdata = opa;
                ACC_OPB:  rdata = opb;
                ACC_ACC:  rdata = acc;
                default:  rdata = {{(WIDTH-3){1'b0}}, ovf, done, busy};
            endcase
        end
    end

endmodule

// File: tb/tb_acc_mac_resp.sv
// Randomized and directed bench for acc_mac_resp against an edge-counting
// behavioural model of the register map and multiply-accumulate.
module tb_acc_mac_resp;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [3:0]   addr;
    logic [3:0]   we;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         busy;

    int n_cmp;
    int n_err;

    // reference model state
    logic [W-1:0] m_opa, m_opb, m_acc, m_prod;
    logic         m_done, m_ovf, m_busy;
    int           m_remain;

    acc_mac_resp #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] cur, input logic [W-1:0] nw,
                                           input logic [3:0] be);
        logic [W-1:0] r;
        r = cur;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [W-1:0] model_read(input logic e, input logic [3:0] a);
        if (!e) return '0;
        case (a[3:2])
            2'd0:    return m_opa;
            2'd1:    return m_opb;
            2'd2:    return m_acc;
            default: return {29'b0, m_ovf, m_done, m_busy};
        endcase
    endfunction

    task automatic model_reset();
        m_opa = '0; m_opb = '0; m_acc = '0; m_prod = '0;
        m_done = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_remain = 0;
    endtask

    // One clock edge of the model: a start captures OPA*OPB mod 2^32 and the
    // sum lands in ACC 33 edges later.
    task automatic model_edge(input logic e, input logic [3:0] a, input logic [3:0] b,
                              input logic [W-1:0] d);
        logic       was_busy;
        logic       wr;
        logic [W:0] s;
        was_busy = m_busy;
        wr = e && (b != 4'b0);
        if (m_busy) begin
            m_remain--;
            if (m_remain == 0) begin
                s = {1'b0, m_acc} + {1'b0, m_prod};
                m_acc  = s[W-1:0];
                m_ovf  = s[W];
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end
        if (wr) begin
            case (a[3:2])
                2'd0: m_opa = merge(m_opa, d, b);
                2'd1: m_opb = merge(m_opb, d, b);
                2'd2: if (!was_busy) m_acc = merge(m_acc, d, b);
                default: begin
                    if (b[0] && d[0] && !was_busy) begin
                        m_prod   = m_opa * m_opb;
                        if (d[1]) m_acc = '0;
                        m_done   = 1'b0;
                        m_ovf    = 1'b0;
                        m_busy   = 1'b1;
                        m_remain = 33;
                    end
                end
            endcase
        end
    endtask

    task automatic bus_cycle(input logic e, input logic [3:0] a, input logic [3:0] b,
                             input logic [W-1:0] d, output logic [W-1:0] obs,
                             output logic obs_busy);
        @(negedge clk);
        en = e; addr = a; we = b; wdata = d;
        #1;
        obs = rdata;
        obs_busy = busy;
        chk("rdata", rdata, model_read(e, a));
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        @(posedge clk);
        model_edge(e, a, b, d);
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [W-1:0] d, input logic [3:0] b);
        logic [W-1:0] o;
        logic         ob;
        bus_cycle(1'b1, {r, 2'b00}, b, d, o, ob);
    endtask

    task automatic rd_reg(input logic [1:0] r, output logic [W-1:0] o);
        logic ob;
        bus_cycle(1'b1, {r, 2'b00}, 4'b0000, '0, o, ob);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; we = 4'b0; addr = 4'b0; wdata = '0;
        repeat (n) begin
            @(posedge clk);
            model_reset();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reads CTRL for a bounded number of cycles, counting busy samples and done rises.
    task automatic run_out(output int busy_cycles, output int done_rises);
        logic [W-1:0] o;
        logic         ob;
        logic         prev_done;
        busy_cycles = 0;
        done_rises  = 0;
        prev_done   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus_cycle(1'b1, 4'hC, 4'b0000, '0, o, ob);
            if (ob) busy_cycles++;
            if (o[1] && !prev_done) done_rises++;
            prev_done = o[1];
        end
        chk("run_bound", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] o;
        logic         ob;
        int           bc, dr;
        logic [3:0]   b;
        logic [1:0]   r;
        logic [W-1:0] d;

        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; en = 1'b0; addr = '0; we = '0; wdata = '0;
        model_reset();

        do_reset(2);
        rd_reg(2'd0, o); chk("rst_opa", o, 32'h0);
        rd_reg(2'd1, o); chk("rst_opb", o, 32'h0);
        rd_reg(2'd2, o); chk("rst_acc", o, 32'h0);
        rd_reg(2'd3, o); chk("rst_ctrl", o, 32'h0);

        // basic 7*6
        wr_reg(2'd0, 32'd7, 4'hF);
        wr_reg(2'd1, 32'd6, 4'hF);
        wr_reg(2'd2, 32'd0, 4'hF);
        wr_reg(2'd3, 32'd1, 4'hF);
        run_out(bc, dr);
        chk("basic_busy_len", bc, 32'd33);
        rd_reg(2'd2, o); chk("basic_acc", o, 32'd42);
        rd_reg(2'd3, o); chk("basic_ctrl", o, 32'h2);

        // accumulate, then clear-and-accumulate
        wr_reg(2'd0, 32'd3, 4'hF);
        wr_reg(2'd1, 32'd5, 4'hF);
        wr_reg(2'd3, 32'd1, 4'hF);
        run_out(bc, dr);
        rd_reg(2'd2, o); chk("accum_acc", o, 32'd57);
        wr_reg(2'd3, 32'd3, 4'hF);
        run_out(bc, dr);
        rd_reg(2'd2, o); chk("clr_acc", o, 32'd15);

        // wrap with carry-out
        wr_reg(2'd2, 32'hFFFF_FFF0, 4'hF);
        wr_reg(2'd0, 32'd4, 4'hF);
        wr_reg(2'd1, 32'd5, 4'hF);
        wr_reg(2'd3, 32'd1, 4'hF);
        run_out(bc, dr);
        rd_reg(2'd2, o); chk("wrap_acc", o, 32'h0000_0004);
        rd_reg(2'd3, o); chk("wrap_ctrl", o, 32'h6);

        // truncated product is zero
        wr_reg(2'd0, 32'h0001_0000, 4'hF);
        wr_reg(2'd1, 32'h0001_0000, 4'hF);
        wr_reg(2'd3, 32'd1, 4'hF);
        run_out(bc, dr);
        rd_reg(2'd2, o); chk("trunc_acc", o, 32'h0000_0004);
        rd_reg(2'd3, o); chk("trunc_ctrl", o, 32'h2);

        // busy lockout
        wr_reg(2'd2, 32'd0, 4'hF);
        wr_reg(2'd0, 32'd7, 4'hF);
        wr_reg(2'd1, 32'd6, 4'hF);
        wr_reg(2'd3, 32'd1, 4'hF);
        wr_reg(2'd2, 32'h1234, 4'hF);
        wr_reg(2'd3, 32'd1, 4'hF);
        wr_reg(2'd0, 32'd9, 4'hF);
        run_out(bc, dr);
        chk("lock_done_once", dr, 32'd1);
        rd_reg(2'd2, o); chk("lock_acc", o, 32'd42);
        rd_reg(2'd0, o); chk("lock_opa", o, 32'd9);

        // byte enables and en gating
        wr_reg(2'd0, 32'd0, 4'hF);
        wr_reg(2'd0, 32'hAABB_CCDD, 4'b0101);
        rd_reg(2'd0, o); chk("be_opa", o, 32'h00BB_00DD);
        for (int i = 0; i < 4; i++) begin
            bus_cycle(1'b0, 4'(i * 4), 4'hF, 32'h0000_0003, o, ob);
            chk("en0_rdata", o, 32'h0);
        end
        rd_reg(2'd0, o); chk("en0_opa", o, 32'h00BB_00DD);
        rd_reg(2'd2, o); chk("en0_acc", o, 32'd42);
        rd_reg(2'd3, o); chk("en0_ctrl", o, 32'h2);

        // reset at E10 of a run
        wr_reg(2'd3, 32'd1, 4'hF);
        repeat (9) bus_cycle(1'b0, 4'h0, 4'h0, '0, o, ob);
        do_reset(1);
        rd_reg(2'd3, o); chk("midrst_ctrl", o, 32'h0);
        rd_reg(2'd2, o); chk("midrst_acc", o, 32'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 4) == 0) b = 4'h0;
            d = $urandom;
            if (r == 2'd3) d = {30'b0, 2'($urandom)};
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else begin
                bus_cycle(($urandom_range(0, 7) != 0), {r, 2'($urandom)}, b, d, o, ob);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
